logic_unit_mc: RTL and testbench
================================

// Module: logic_unit_mc
// PURPOSE
//  Multicycle, parametrised bitwise logic unit for the MiniMIPS ALU path. Generalises the fixed 32-bit NOR array.
//  Computes AND/OR/XOR/NOR on WIDTH-bit operands, SLICE bits per cycle, to trade area for latency.
//  Uses valid/ready handshakes on input and output. Sits between decode/operand fetch and ALU result mux.
// PARAMETERS
//  WIDTH  32  operand/result width in bits; WIDTH % SLICE == 0, otherwise $error at elaboration
//  SLICE   8  bits processed per cycle; NSLICE = WIDTH/SLICE; SLICE == WIDTH gives a single-cycle BUSY
// PORTS
//  clk        in   1      single clock; all state on rising edge
//  rst_n      in   1      asynchronous assert, active-low reset
//  in_valid   in   1      operands/op presented
//  in_ready   out  1      unit can accept; == (state==IDLE)
//  op         in   2      lu_op_t: 00 AND, 01 OR, 10 XOR, 11 NOR
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  out_valid  out  1      result held stable
//  out_ready  in   1      consumer accepts result
//  result     out  WIDTH  bitwise result
//  zero       out  1      only with LOGIC_UNIT_ZFLAG_EN: result == 0
// BEHAVIOUR
//  Reset (rst_n=0, takes effect immediately): state=IDLE, idx=0, out_valid=0, result=0, zero=0, a/b/op regs=0.
//   in_ready=1 once in IDLE.
//  Reset mid-operation aborts the operation. The operation is not resumed, and out_valid stays 0.
//  FSM IDLE: in_valid&&in_ready on edge -> latch a,b,op; idx=0; result=0 -> BUSY.
//  FSM BUSY: each edge -> result[idx*SLICE +: SLICE] = f(op, a_slice, b_slice); idx++.
//   When idx==NSLICE-1 -> DONE, out_valid=1 on the same edge.
//   in_valid is ignored in BUSY.
//  FSM DONE: result, zero and out_valid are held stable.
//   out_valid&&out_ready on edge -> out_valid=0 -> IDLE.
//   No back-to-back bypass: a new accept is possible at the earliest one edge after the result handshake.
//  Latency: accept on edge k -> out_valid high after edge k+NSLICE.
//   Throughput: one op per NSLICE+2 cycles when out_ready is held 1.
//  Busy-slice result bits: unwritten slices read 0. Consumers sample only on out_valid.
//  idx is $clog2(NSLICE) bits (minimum 1) and never wraps past NSLICE-1.
//  NOR computes ~(a|b) per bit, so all-zero operands give all-ones.
//  Inputs a, b, op need to be held only on the accept edge.
// CONFIGURATION
//  `LOGIC_UNIT_ZFLAG_EN defined: zero port exists.
//   Zero flag is accumulated during BUSY: zero_acc &= ~|slice; zero_acc is set to 1 at accept.
//   zero is valid with out_valid.
//  Macro undefined: no zero port and no accumulator. All other timing is identical.
// STRUCTURE
//  logic_unit_pkg: typedef enum logic[1:0] lu_op_t {LU_AND, LU_OR, LU_XOR, LU_NOR};
//   typedef enum logic[1:0] lu_state_t {LU_IDLE, LU_BUSY, LU_DONE}.
//  Sub-module logic_slice #(SLICE): combinational, inputs op/a/b (SLICE bits), output y.
//   Instantiated once and muxed by idx.
// TESTING
//  1 Reset: rst_n=0 mid-BUSY -> out_valid=0, result=0 immediately; after release in_ready=1, state IDLE.
//  2 NOR, WIDTH=32, SLICE=8: a=0, b=0 -> result=32'hFFFF_FFFF; out_valid rises 4 edges after accept.
//  3 All ops, a=32'hF0F0_1234, b=32'h0FF0_FFFF -> AND 32'h00F0_1234, OR 32'hFFF0_FFFF,
//    XOR 32'hFF00_EDCB, NOR 32'h000F_0000.
//  4 Backpressure: out_ready=0 for 5 cycles in DONE -> result stable, in_ready=0.
//    A new in_valid during that time is not accepted.
//  5 SLICE=WIDTH=16: AND a=16'hFFFF, b=16'h00FF -> 16'h00FF after 1 edge.
//    Random 1000-op run vs reference model, random out_ready.
//  6 LOGIC_UNIT_ZFLAG_EN: XOR a=b=32'hDEAD_BEEF -> result=0, zero=1.
//    OR a=1, b=0 -> zero=0.

Source files
------------

// File: rtl/logic_unit_pkg.sv
// Shared types for the multicycle logic unit: operation and FSM state encodings.
package logic_unit_pkg;

  typedef enum logic [1:0] {LU_AND, LU_OR, LU_XOR, LU_NOR} lu_op_t;
  typedef enum logic [1:0] {LU_IDLE, LU_BUSY, LU_DONE} lu_state_t;

  // Slice index width; a single-slice unit still carries a 1-bit index.
  function automatic int idx_bits(input int nslice);
    return (nslice > 1) ? $clog2(nslice) : 1;
  endfunction

endpackage

// File: rtl/logic_unit_mc_slice.sv
// Combinational SLICE-bit bitwise operator shared by every slice of the multicycle unit.
module logic_slice
  import logic_unit_pkg::*;
#(
  parameter int SLICE = 8
) (
  input  lu_op_t           op,
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  output logic [SLICE-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      LU_AND:  y = a & b;
      LU_OR:   y = a | b;
      LU_XOR:  y = a ^ b;
      LU_NOR:  y = ~(a | b);
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/logic_unit_mc.sv
// Multicycle WIDTH-bit AND/OR/XOR/NOR unit, SLICE bits per cycle, valid/ready on both sides.
// Optional zero flag output is enabled by defining LOGIC_UNIT_ZFLAG_EN.
module logic_unit_mc
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result
`ifdef LOGIC_UNIT_ZFLAG_EN
  ,
  output logic             zero
`endif
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = idx_bits(NSLICE);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  if (WIDTH % SLICE != 0) begin : g_bad_slice
    $error("logic_unit_mc: WIDTH must be a multiple of SLICE");
  end

  lu_state_t        state_reg;
  logic [IDXW-1:0]  idx_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  lu_op_t           op_reg;
  logic [WIDTH-1:0] result_reg;
  logic [WIDTH-1:0] result_next;
  logic             out_valid_reg;
  logic [SLICE-1:0] a_cur;
  logic [SLICE-1:0] b_cur;
  logic [SLICE-1:0] y_cur;

  // One operator instance; the current slice is selected by shifting the latched operands.
  assign a_cur = SLICE'(a_reg >> (SLICE * int'(idx_reg)));
  assign b_cur = SLICE'(b_reg >> (SLICE * int'(idx_reg)));

  logic_slice #(.SLICE(SLICE)) u_slice (
    .op (op_reg),
    .a  (a_cur),
    .b  (b_cur),
    .y  (y_cur)
  );

  for (genvar gi = 0; gi < NSLICE; gi++) begin : g_slot
    assign result_next[gi*SLICE +: SLICE] =
      (state_reg == LU_BUSY && idx_reg == IDXW'(gi)) ? y_cur : result_reg[gi*SLICE +: SLICE];
  end

`ifdef LOGIC_UNIT_ZFLAG_EN
  logic zero_acc_reg;
  assign zero = zero_acc_reg;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= LU_IDLE;
      idx_reg       <= '0;
      a_reg         <= '0;
      b_reg         <= '0;
      op_reg        <= LU_AND;
      result_reg    <= '0;
      out_valid_reg <= 1'b0;
`ifdef LOGIC_UNIT_ZFLAG_EN
      zero_acc_reg  <= 1'b0;
`endif
    end else begin
      case (state_reg)
        LU_IDLE: begin
          if (in_valid) begin
            a_reg      <= a;
            b_reg      <= b;
            op_reg     <= lu_op_t'(op);
            idx_reg    <= '0;
            result_reg <= '0;
`ifdef LOGIC_UNIT_ZFLAG_EN
            zero_acc_reg <= 1'b1;
`endif
            state_reg  <= LU_BUSY;
          end
        end
        LU_BUSY: begin
          result_reg <= result_next;
`ifdef LOGIC_UNIT_ZFLAG_EN
          zero_acc_reg <= zero_acc_reg & ~(|y_cur);
`endif
          // idx parks on the last slice rather than wrapping.
          if (idx_reg == LAST_IDX) begin
            state_reg     <= LU_DONE;
            out_valid_reg <= 1'b1;
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        LU_DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            state_reg     <= LU_IDLE;
          end
        end
        default: state_reg <= LU_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_reg == LU_IDLE);
  assign out_valid = out_valid_reg;
  assign result    = result_reg;

endmodule

// File: tb/tb_logic_unit_mc.sv
// Self-checking bench for logic_unit_mc: a 32/8 instance and a 16/16 instance vs a bitwise reference model.
module tb_logic_unit_mc;

  logic clk;
  logic rst_n;

  logic        iv32, ir32, ov32, ordy32;
  logic [1:0]  op32;
  logic [31:0] a32, b32, res32;
  logic        z32;

  logic        iv16, ir16, ov16, ordy16;
  logic [1:0]  op16;
  logic [15:0] a16, b16, res16;
  logic        z16;

  int errors = 0;
  int checks = 0;

  logic_unit_mc #(.WIDTH(32), .SLICE(8)) dut32 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (iv32),
    .in_ready  (ir32),
    .op        (op32),
    .a         (a32),
    .b         (b32),
    .out_valid (ov32),
    .out_ready (ordy32),
    .result    (res32)
`ifdef LOGIC_UNIT_ZFLAG_EN
    ,
    .zero      (z32)
`endif
  );

  logic_unit_mc #(.WIDTH(16), .SLICE(16)) dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (iv16),
    .in_ready  (ir16),
    .op        (op16),
    .a         (a16),
    .b         (b16),
    .out_valid (ov16),
    .out_ready (ordy16),
    .result    (res16)
`ifdef LOGIC_UNIT_ZFLAG_EN
    ,
    .zero      (z16)
`endif
  );

`ifndef LOGIC_UNIT_ZFLAG_EN
  assign z32 = 1'b0;
  assign z16 = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the four bitwise operations straight from their definitions.
  function automatic logic [31:0] ref_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a ^ b;
      default: return ~(a | b);
    endcase
  endfunction

  // Drive one op into dut32, return result, zero flag and edges from accept to out_valid.
  task automatic run_op32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output logic z, output int lat);
    int n;
    n = 0;
    while (!ir32 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    op32 = op; a32 = a; b32 = b; iv32 = 1'b1;
    @(posedge clk); #1;
    iv32 = 1'b0;
    a32 = $urandom; b32 = $urandom; op32 = 2'($urandom);
    lat = 0;
    while (!ov32 && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    res = res32;
    z   = z32;
    ordy32 = 1'b1;
    @(posedge clk); #1;
    ordy32 = 1'b0;
  endtask

  task automatic test_reset();
    bit stayed_low;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (ov32 !== 1'b0 || res32 !== 32'h0 || ir32 !== 1'b1) begin
      errors++;
      $display("FAIL reset_state got ov=%b res=%h ir=%b exp ov=0 res=00000000 ir=1", ov32, res32, ir32);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    op32 = 2'd1; a32 = 32'hFFFF_FFFF; b32 = 32'h0; iv32 = 1'b1;
    @(posedge clk); #1;
    iv32 = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (ov32 !== 1'b0 || res32 !== 32'h0) begin
      errors++;
      $display("FAIL reset_midbusy got ov=%b res=%h exp ov=0 res=00000000", ov32, res32);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (ir32 !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready got ir=%b exp ir=1", ir32);
    end
    stayed_low = 1'b1;
    repeat (8) begin
      @(posedge clk); #1;
      if (ov32 !== 1'b0) stayed_low = 1'b0;
    end
    checks++;
    if (!stayed_low || ir32 !== 1'b1) begin
      errors++;
      $display("FAIL reset_no_resume got stayed_low=%b ir=%b exp stayed_low=1 ir=1", stayed_low, ir32);
    end
  endtask

  task automatic test_nor_zero_operands();
    logic [31:0] r; logic z; int lat;
    run_op32(2'd3, 32'h0, 32'h0, r, z, lat);
    checks++;
    if (r !== 32'hFFFF_FFFF || lat != 4) begin
      errors++;
      $display("FAIL nor_zero got res=%h lat=%0d exp res=ffffffff lat=4", r, lat);
    end
  endtask

  task automatic test_all_ops();
    logic [31:0] exp_tab [4];
    logic [31:0] r; logic z; int lat;
    exp_tab[0] = 32'h00F0_1234;
    exp_tab[1] = 32'hFFF0_FFFF;
    exp_tab[2] = 32'hFF00_EDCB;
    exp_tab[3] = 32'h000F_0000;
    for (int i = 0; i < 4; i++) begin
      run_op32(2'(i), 32'hF0F0_1234, 32'h0FF0_FFFF, r, z, lat);
      checks++;
      if (r !== exp_tab[i] || lat != 4) begin
        errors++;
        $display("FAIL all_ops op=%0d got res=%h lat=%0d exp res=%h lat=4", i, r, lat, exp_tab[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] ea, eb, hold;
    int n;
    ea = $urandom; eb = $urandom;
    op32 = 2'd2; a32 = ea; b32 = eb; iv32 = 1'b1;
    @(posedge clk); #1;
    iv32 = 1'b0;
    n = 0;
    while (!ov32 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    hold = res32;
    checks++;
    if (hold !== ref_op(2'd2, ea, eb) || n != 4) begin
      errors++;
      $display("FAIL bp_result got res=%h lat=%0d exp res=%h lat=4", hold, n, ref_op(2'd2, ea, eb));
    end
    iv32 = 1'b1; op32 = 2'd1; a32 = ~ea; b32 = 32'h1234_5678;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++;
      if (ov32 !== 1'b1 || ir32 !== 1'b0 || res32 !== hold) begin
        errors++;
        $display("FAIL bp_hold cyc=%0d got ov=%b ir=%b res=%h exp ov=1 ir=0 res=%h", c, ov32, ir32, res32, hold);
      end
    end
    iv32 = 1'b0;
    ordy32 = 1'b1;
    @(posedge clk); #1;
    ordy32 = 1'b0;
    checks++;
    if (ov32 !== 1'b0 || ir32 !== 1'b1) begin
      errors++;
      $display("FAIL bp_release got ov=%b ir=%b exp ov=0 ir=1", ov32, ir32);
    end
  endtask

  // in_valid and out_ready held high: accepts must be NSLICE+2 = 6 edges apart.
  task automatic test_back_to_back();
    logic [31:0] q[$];
    logic [31:0] e;
    int last_acc, naccs, nres;
    last_acc = -1; naccs = 0; nres = 0;
    ordy32 = 1'b1;
    for (int cyc = 0; cyc < 80; cyc++) begin
      a32 = $urandom; b32 = $urandom; op32 = 2'($urandom);
      iv32 = (cyc < 60);
      if (ov32 && ordy32) begin
        e = (q.size() > 0) ? q.pop_front() : 32'hx;
        nres++;
        checks++;
        if (res32 !== e) begin
          errors++;
          $display("FAIL b2b_result cyc=%0d got %h exp %h", cyc, res32, e);
        end
      end
      if (iv32 && ir32) begin
        q.push_back(ref_op(op32, a32, b32));
        if (last_acc >= 0) begin
          checks++;
          if (cyc - last_acc != 6) begin
            errors++;
            $display("FAIL b2b_spacing got %0d exp 6", cyc - last_acc);
          end
        end
        last_acc = cyc;
        naccs++;
      end
      @(posedge clk); #1;
    end
    iv32 = 1'b0;
    ordy32 = 1'b0;
    checks++;
    if (q.size() != 0 || naccs < 5) begin
      errors++;
      $display("FAIL b2b_drain got pending=%0d accepts=%0d exp pending=0 accepts>=5", q.size(), naccs);
    end
  endtask

  task automatic test_slice16();
    logic [15:0] q[$];
    logic [15:0] e;
    int n, ndone, cyc;
    op16 = 2'd0; a16 = 16'hFFFF; b16 = 16'h00FF; iv16 = 1'b1; ordy16 = 1'b0;
    @(posedge clk); #1;
    iv16 = 1'b0;
    n = 0;
    while (!ov16 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (res16 !== 16'h00FF || n != 1) begin
      errors++;
      $display("FAIL s16_and got res=%h lat=%0d exp res=00ff lat=1", res16, n);
    end
    ordy16 = 1'b1;
    @(posedge clk); #1;
    ndone = 0;
    cyc = 0;
    while (ndone < 1000 && cyc < 20000) begin
      a16 = 16'($urandom); b16 = 16'($urandom); op16 = 2'($urandom);
      iv16 = 1'($urandom); ordy16 = 1'($urandom);
      if (ov16 && ordy16) begin
        e = (q.size() > 0) ? q.pop_front() : 16'hx;
        ndone++;
        checks++;
        if (res16 !== e) begin
          errors++;
          $display("FAIL s16_random n=%0d got %h exp %h", ndone, res16, e);
        end
`ifdef LOGIC_UNIT_ZFLAG_EN
        checks++;
        if (z16 !== (e == 16'h0)) begin
          errors++;
          $display("FAIL s16_zero n=%0d got %b exp %b", ndone, z16, (e == 16'h0));
        end
`endif
      end
      if (iv16 && ir16) q.push_back(16'(ref_op(op16, {16'h0, a16}, {16'h0, b16})));
      @(posedge clk); #1;
      cyc++;
    end
    iv16 = 1'b0;
    ordy16 = 1'b0;
    checks++;
    if (ndone != 1000) begin
      errors++;
      $display("FAIL s16_timeout got %0d results exp 1000", ndone);
    end
  endtask

  task automatic test_zero_flag();
`ifdef LOGIC_UNIT_ZFLAG_EN
    logic [31:0] r; logic z; int lat;
    run_op32(2'd2, 32'hDEAD_BEEF, 32'hDEAD_BEEF, r, z, lat);
    checks++;
    if (r !== 32'h0 || z !== 1'b1) begin
      errors++;
      $display("FAIL zflag_xor got res=%h z=%b exp res=00000000 z=1", r, z);
    end
    run_op32(2'd1, 32'h1, 32'h0, r, z, lat);
    checks++;
    if (r !== 32'h1 || z !== 1'b0) begin
      errors++;
      $display("FAIL zflag_or got res=%h z=%b exp res=00000001 z=0", r, z);
    end
`endif
  endtask

  initial begin
    iv32 = 1'b0; ordy32 = 1'b0; op32 = 2'd0; a32 = '0; b32 = '0;
    iv16 = 1'b0; ordy16 = 1'b0; op16 = 2'd0; a16 = '0; b16 = '0;
    test_reset();
    test_nor_zero_operands();
    test_all_ops();
    test_backpressure();
    test_back_to_back();
    test_slice16();
    test_zero_flag();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
